decade_bin_converter: RTL and testbench

Sequential, parametrised converter between multi-digit dekatron-style one-hot decade values (10 position lines per digit) and plain binary.
- Mode 0, decade→binary: Horner accumulation, one digit per cycle.
- Mode 1, binary→decade: shift-add-3 (double dabble), one bit per cycle, then BCD→one-hot per digit.
- Both modes use a valid/ready handshake on input and output.
- It sits between the dekatron counter/register banks and the binary datapath/IO.

---
 rtl/decade_pkg.sv | 77 +++++++
 rtl/decade_digit_codec.sv | 20 ++
 rtl/decade_bin_converter.sv | 222 ++++++++++++++++++++++
 tb/tb_decade_bin_converter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/decade_pkg.sv
// Shared constants, state encoding and digit conversion helpers for the
// decade/binary converter.
package decade_pkg;

    localparam int DEC_W = 10;
    localparam int BCD_W = 4;

    // A decade digit holding the value zero: only position line 0 is hot.
    localparam logic [DEC_W-1:0] ONEHOT_ZERO = 10'b00_0000_0001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_D2B  = 2'd1,
        ST_B2D  = 2'd2,
        ST_DONE = 2'd3
    } conv_state_e;

    // Nibble to position line; out-of-range nibbles give no hot line.
    function automatic logic [DEC_W-1:0] bcd_to_onehot(input logic [BCD_W-1:0] bcd);
        logic [DEC_W-1:0] onehot;
        case (bcd)
            4'd0:    onehot = 10'b00_0000_0001;
            4'd1:    onehot = 10'b00_0000_0010;
            4'd2:    onehot = 10'b00_0000_0100;
            4'd3:    onehot = 10'b00_0000_1000;
            4'd4:    onehot = 10'b00_0001_0000;
            4'd5:    onehot = 10'b00_0010_0000;
            4'd6:    onehot = 10'b00_0100_0000;
            4'd7:    onehot = 10'b00_1000_0000;
            4'd8:    onehot = 10'b01_0000_0000;
            4'd9:    onehot = 10'b10_0000_0000;
            default: onehot = 10'b00_0000_0000;
        endcase
        return onehot;
    endfunction

    // Position line to nibble; anything not exactly one-hot reads as zero
    // and must be qualified with onehot_valid.
    function automatic logic [BCD_W-1:0] onehot_to_bcd(input logic [DEC_W-1:0] onehot);
        logic [BCD_W-1:0] bcd;
        case (onehot)
            10'b00_0000_0001: bcd = 4'd0;
            10'b00_0000_0010: bcd = 4'd1;
            10'b00_0000_0100: bcd = 4'd2;
            10'b00_0000_1000: bcd = 4'd3;
            10'b00_0001_0000: bcd = 4'd4;
            10'b00_0010_0000: bcd = 4'd5;
            10'b00_0100_0000: bcd = 4'd6;
            10'b00_1000_0000: bcd = 4'd7;
            10'b01_0000_0000: bcd = 4'd8;
            10'b10_0000_0000: bcd = 4'd9;
            default:          bcd = 4'd0;
        endcase
        return bcd;
    endfunction

    // True when exactly one position line is hot.
    function automatic logic onehot_valid(input logic [DEC_W-1:0] onehot);
        logic [3:0] count;
        count = 4'd0;
        for (int i = 0; i < DEC_W; i++) begin
            count = count + {3'b000, onehot[i]};
        end
        return (count == 4'd1);
    endfunction

    // 10**n, used at elaboration for the width check and the range limit.
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] result;
        result = 64'd1;
        for (int i = 0; i < n; i++) begin
            result = result * 64'd10;
        end
        return result;
    endfunction

endpackage

// File: rtl/decade_digit_codec.sv
// Per-digit codec: one-hot position lines to nibble (with legality flag)
// and nibble back to one-hot position lines.
module decade_digit_codec
    import decade_pkg::*;
(
    input  logic [DEC_W-1:0] onehot,
    input  logic [BCD_W-1:0] bcd,
    output logic [BCD_W-1:0] value,
    output logic             legal,
    output logic [DEC_W-1:0] expanded
);

    // Both conversion directions are pure combinational lookups.
    always_comb begin
        value    = onehot_to_bcd(onehot);
        legal    = onehot_valid(onehot);
        expanded = bcd_to_onehot(bcd);
    end

endmodule

// File: rtl/decade_bin_converter.sv
// Sequential converter between one-hot decade digits and binary.
// Mode 0 runs Horner accumulation one digit per cycle; mode 1 runs
// shift-add-3 one bit per cycle and expands the BCD result to one-hot.
module decade_bin_converter
    import decade_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    mode,
    input  logic [DIGITS*DEC_W-1:0] digits_in,
    input  logic [BIN_W-1:0]        bin_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BIN_W-1:0]        bin_out,
    output logic [DIGITS*DEC_W-1:0] digits_out,
    output logic                    err
);

    localparam int NIB_W  = DIGITS * BCD_W;
    localparam int STEP_W = $clog2(BIN_W + 1);
    localparam logic [63:0] BIN_SPAN = 64'd1 << BIN_W;
    localparam logic [63:0] DEC_SPAN = pow10(DIGITS);
    localparam logic [DIGITS*DEC_W-1:0] DIGITS_ZERO = {DIGITS{ONEHOT_ZERO}};
    localparam logic [STEP_W-1:0] D2B_LAST = STEP_W'(DIGITS - 1);
    localparam logic [STEP_W-1:0] B2D_LAST = STEP_W'(BIN_W - 1);

    if (BIN_SPAN < DEC_SPAN) begin : g_param_check
        $error("decade_bin_converter: BIN_W too narrow for DIGITS decade digits");
    end

    conv_state_e              state_r;
    conv_state_e              state_next_s;
    logic [BIN_W-1:0]         acc_r;
    logic [BIN_W-1:0]         bin_r;
    logic [NIB_W-1:0]         bcd_r;
    logic [STEP_W-1:0]        step_r;
    logic                     err_r;
    logic                     ovf_r;
    logic                     accept_s;
    logic                     last_s;
    logic                     step_ovf_s;
    logic                     result_err_s;
    logic                     too_big_s;
    logic                     capture_err_s;
    logic [BIN_W+3:0]         acc_ext_s;
    logic [BIN_W+3:0]         horner_s;
    logic                     horner_ovf_s;
    logic [NIB_W-1:0]         adjusted_s;
    logic [NIB_W-1:0]         bcd_shift_s;
    logic [NIB_W-1:0]         values_s;
    logic [DIGITS-1:0]        legal_s;
    logic [DIGITS*DEC_W-1:0]  expanded_s;

    // The codec decodes the request digits for capture and expands the
    // next BCD value so the result can be registered on the final step.
    for (genvar g = 0; g < DIGITS; g++) begin : g_codec
        decade_digit_codec u_codec (
            .onehot   (digits_in[DEC_W*g +: DEC_W]),
            .bcd      (bcd_shift_s[BCD_W*g +: BCD_W]),
            .value    (values_s[BCD_W*g +: BCD_W]),
            .legal    (legal_s[g]),
            .expanded (expanded_s[DEC_W*g +: DEC_W])
        );
    end

    assign accept_s      = in_valid & in_ready & (state_r == ST_IDLE);
    assign too_big_s     = {{(64-BIN_W){1'b0}}, bin_in} > (DEC_SPAN - 64'd1);
    assign capture_err_s = mode ? too_big_s : ~(&legal_s);
    // Lost high bits cannot occur for legal input; folding them into the
    // error keeps a corrupted result from ever looking valid.
    assign result_err_s  = err_r | ovf_r | step_ovf_s;

    // One Horner step (acc*10 + top digit) and one shift-add-3 step.
    always_comb begin
        acc_ext_s    = {4'b0000, acc_r};
        horner_s     = (acc_ext_s << 3'd3) + (acc_ext_s << 3'd1)
                     + {{BIN_W{1'b0}}, bcd_r[NIB_W-1 -: BCD_W]};
        horner_ovf_s = |horner_s[BIN_W+3:BIN_W];
        adjusted_s   = bcd_r;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_r[BCD_W*i +: BCD_W] >= 4'd5) begin
                adjusted_s[BCD_W*i +: BCD_W] = bcd_r[BCD_W*i +: BCD_W] + 4'd3;
            end else begin
                adjusted_s[BCD_W*i +: BCD_W] = bcd_r[BCD_W*i +: BCD_W];
            end
        end
        bcd_shift_s  = {adjusted_s[NIB_W-2:0], bin_r[BIN_W-1]};
    end

    // Next-state logic and final-step detection.
    always_comb begin
        state_next_s = state_r;
        last_s       = 1'b0;
        step_ovf_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = mode ? ST_B2D : ST_D2B;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_D2B: begin
                last_s     = (step_r == D2B_LAST);
                step_ovf_s = horner_ovf_s;
                if (last_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_D2B;
                end
            end
            ST_B2D: begin
                last_s     = (step_r == B2D_LAST);
                step_ovf_s = adjusted_s[NIB_W-1];
                if (last_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_B2D;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Working registers: request capture, accumulator, BCD shifter, step count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r  <= '0;
            bin_r  <= '0;
            bcd_r  <= '0;
            step_r <= '0;
            err_r  <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        acc_r  <= '0;
                        step_r <= '0;
                        ovf_r  <= 1'b0;
                        err_r  <= capture_err_s;
                        if (mode) begin
                            bcd_r <= '0;
                            bin_r <= bin_in;
                        end else begin
                            bcd_r <= values_s;
                            bin_r <= '0;
                        end
                    end
                end
                ST_D2B: begin
                    acc_r  <= horner_s[BIN_W-1:0];
                    bcd_r  <= bcd_r << 3'd4;
                    step_r <= step_r + STEP_W'(1);
                    ovf_r  <= ovf_r | horner_ovf_s;
                end
                ST_B2D: begin
                    bcd_r  <= bcd_shift_s;
                    bin_r  <= bin_r << 1'b1;
                    step_r <= step_r + STEP_W'(1);
                    ovf_r  <= ovf_r | adjusted_s[NIB_W-1];
                end
                default: begin
                end
            endcase
        end
    end

    // Result registers: loaded on the final step, held through DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            bin_out    <= '0;
            digits_out <= DIGITS_ZERO;
            err        <= 1'b0;
        end else if (last_s) begin
            out_valid <= 1'b1;
            err       <= result_err_s;
            if (state_r == ST_D2B) begin
                bin_out    <= result_err_s ? '0 : horner_s[BIN_W-1:0];
                digits_out <= DIGITS_ZERO;
            end else begin
                bin_out    <= '0;
                digits_out <= result_err_s ? DIGITS_ZERO : expanded_s;
            end
        end else if ((state_r == ST_DONE) && out_ready) begin
            out_valid <= 1'b0;
            err       <= 1'b0;
        end
    end

    // Ready is low throughout reset and rises on the first edge after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready <= 1'b0;
        end else begin
            in_ready <= (state_next_s == ST_IDLE);
        end
    end

endmodule

// File: tb/tb_decade_bin_converter.sv
module tb_decade_bin_converter;

    localparam int DIGITS = 3;
    localparam int BIN_W  = 10;
    localparam int DW     = DIGITS * 10;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b1;
    logic              in_valid  = 1'b0;
    logic              mode      = 1'b0;
    logic              out_ready = 1'b0;
    logic [DW-1:0]     digits_in = '0;
    logic [BIN_W-1:0]  bin_in    = '0;
    logic              in_ready;
    logic              out_valid;
    logic              err;
    logic [BIN_W-1:0]  bin_out;
    logic [DW-1:0]     digits_out;

    int errors = 0;
    int checks = 0;

    decade_bin_converter #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mode       (mode),
        .digits_in  (digits_in),
        .bin_in     (bin_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .bin_out    (bin_out),
        .digits_out (digits_out),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pow10i(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [DW-1:0] zero_digits();
        logic [DW-1:0] r = '0;
        for (int i = 0; i < DIGITS; i++) r[10*i] = 1'b1;
        return r;
    endfunction

    // Decimal value -> one-hot digits by plain division.
    function automatic logic [DW-1:0] digits_of(input int v);
        logic [DW-1:0] r = '0;
        for (int i = 0; i < DIGITS; i++) r[10*i + (v / pow10i(i)) % 10] = 1'b1;
        return r;
    endfunction

    // One-hot digits -> decimal value, flagging any digit not exactly one-hot.
    task automatic model_d2b(input logic [DW-1:0] d, output int val, output bit bad);
        logic [9:0] seg;
        val = 0;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            seg = d[10*i +: 10];
            if ($countones(seg) != 1) bad = 1'b1;
            for (int n = 0; n < 10; n++) if (seg[n]) val = val + n * pow10i(i);
        end
    endtask

    // Issue one request from a negedge and follow it through the handshake.
    task automatic run_request(input bit m, input logic [DW-1:0] d, input logic [BIN_W-1:0] b,
                               input int hold, input bit poke, input string tag);
        int               exp_lat;
        logic [BIN_W-1:0] exp_bin;
        logic [DW-1:0]    exp_dig;
        bit               exp_err;
        int               v;
        bit               bad;
        int               lat;
        if (!m) begin
            model_d2b(d, v, bad);
            exp_lat = DIGITS;
            exp_err = bad;
            exp_bin = bad ? '0 : BIN_W'(v);
            exp_dig = zero_digits();
        end else begin
            exp_lat = BIN_W;
            exp_err = (int'(b) > pow10i(DIGITS) - 1);
            exp_bin = '0;
            exp_dig = exp_err ? zero_digits() : digits_of(int'(b));
        end
        out_ready = (hold == 0);
        mode      = m;
        digits_in = d;
        bin_in    = b;
        in_valid  = 1'b1;
        check({tag, "_in_ready"}, in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        mode      = ~m;
        digits_in = DW'({$urandom, $urandom});
        bin_in    = BIN_W'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_out_valid"}, out_valid, 1'b1);
        check({tag, "_bin_out"}, bin_out, exp_bin);
        check({tag, "_digits_out"}, digits_out, exp_dig);
        check({tag, "_err"}, err, exp_err);
        check({tag, "_busy_ready"}, in_ready, 1'b0);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, out_valid, 1'b1);
            check({tag, "_hold_bin"}, bin_out, exp_bin);
            check({tag, "_hold_digits"}, digits_out, exp_dig);
            check({tag, "_hold_err"}, err, exp_err);
            check({tag, "_hold_ready"}, in_ready, 1'b0);
            if (poke && k == 1) in_valid = 1'b1;
            if (poke && k == 2) in_valid = 1'b0;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_drop_valid"}, out_valid, 1'b0);
        check({tag, "_drop_ready"}, in_ready, 1'b1);
        check({tag, "_drop_err"}, err, 1'b0);
        if (poke) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                check({tag, "_no_queue"}, out_valid, 1'b0);
            end
        end
    endtask

    initial begin
        logic [DW-1:0] d;
        bit seen;

        // Reset state.
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_bin_out", bin_out, '0);
        check("rst_err", err, 1'b0);
        check("rst_digits_out", digits_out, zero_digits());
        rst_n = 1'b1;
        #1 check("rst_release_ready_low", in_ready, 1'b0);
        @(negedge clk);
        check("rst_release_ready", in_ready, 1'b1);

        // Decade to binary: digits 9,8,7.
        d = '0; d[29] = 1'b1; d[18] = 1'b1; d[7] = 1'b1;
        run_request(1'b0, d, '0, 0, 1'b0, "d2b_987");

        // Binary to decade, in range and at the edges of the range.
        run_request(1'b1, '0, 10'd999, 0, 1'b0, "b2d_999");
        run_request(1'b1, '0, 10'd0, 0, 1'b0, "b2d_0");
        run_request(1'b1, '0, 10'd1000, 0, 1'b0, "b2d_1000");
        run_request(1'b1, '0, 10'd1023, 0, 1'b0, "b2d_1023");

        // Illegal decade digits: two lines hot, then no line hot.
        d = '0; d[25] = 1'b1; d[13] = 1'b1; d[15] = 1'b1; d[2] = 1'b1;
        run_request(1'b0, d, '0, 0, 1'b0, "d2b_twohot");
        d = '0; d[23] = 1'b1; d[17] = 1'b1;
        run_request(1'b0, d, '0, 0, 1'b0, "d2b_nohot");

        // Backpressure with an ignored request pulse.
        d = '0; d[21] = 1'b1; d[14] = 1'b1; d[6] = 1'b1;
        run_request(1'b0, d, '0, 5, 1'b1, "backpressure");

        // Randomized requests with random backpressure.
        for (int t = 0; t < 24; t++) begin
            bit m;
            m = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) != 0) begin
                d = '0;
                for (int i = 0; i < DIGITS; i++) d[10*i + $urandom_range(0, 9)] = 1'b1;
            end else begin
                d = DW'({$urandom, $urandom});
            end
            run_request(m, d, BIN_W'($urandom), $urandom_range(0, 3), 1'b0, "random");
        end

        // Asynchronous reset during the fourth shift-add-3 cycle.
        mode     = 1'b1;
        bin_in   = 10'd555;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 1'b0);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_bin_out", bin_out, '0);
        check("midrst_err", err, 1'b0);
        check("midrst_digits_out", digits_out, zero_digits());
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_ready_after", in_ready, 1'b1);
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        check("midrst_no_result", seen, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
